// File: rtl/fp_alu_seq.sv
// Sequential minifloat ALU: add/sub/mul over {sign, exp, man} words with an
// iterative one-bit-per-cycle normaliser, round-to-nearest-even and exception flags.
module fp_alu_seq #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int SW   = MAN_W + 4;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 3;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0]    EXP_INC  = EW'(1);
  localparam logic [W-1:0]     NAN_WORD = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic is_nan(input logic [W-1:0] x);
    is_nan = (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] != {MAN_W{1'b0}});
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    is_inf = (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] == {MAN_W{1'b0}});
  endfunction

  // Right shift that ORs every bit pushed off the end into the sticky position.
  function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] v, input logic [EXP_W-1:0] d);
    logic [2*SW-1:0] ext;
    int              dc;
    dc  = (int'(d) > SW) ? SW : int'(d);
    ext = {v, {SW{1'b0}}} >> dc;
    shr_sticky = ext[2*SW-1:SW] | {{(SW-1){1'b0}}, |ext[SW-1:0]};
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           sign_q, sign_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic [SW-1:0]  sig_q, sig_d;
  logic           spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0]   spec_word_q, spec_word_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic             sa, sb_eff, s_mul, eff_sub, a_big, carry;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml;
  logic             zero_a, zero_b, nan_a, nan_b, inf_a, inf_b;
  logic [SW-1:0]    sig_a, sig_b, s_big, s_sml, sml_al, add_sig, mul_sig;
  logic [SW:0]      sum;
  logic [PW-1:0]    prod;
  logic [PW+SW-1:0] pext;
  logic [EW-1:0]    add_exp, mul_exp;
  logic             spec, spec_inv;
  logic [W-1:0]     spec_word;

  logic             rnd_up, rnd_lost;
  logic [MAN_W+1:0] man_rnd;
  logic [EW-1:0]    exp_rnd;
  logic [W-1:0]     rnd_word;
  logic [3:0]       rnd_flags;

  // Operand unpack, special-case resolution and the add/sub and mul datapaths
  always_comb begin
    sa      = a_q[W-1];
    sb_eff  = b_q[W-1] ^ (op_q == 2'd1);
    s_mul   = a_q[W-1] ^ b_q[W-1];
    eff_sub = (sa != sb_eff);
    ea      = a_q[W-2:MAN_W];
    eb      = b_q[W-2:MAN_W];
    zero_a  = (ea == {EXP_W{1'b0}});
    zero_b  = (eb == {EXP_W{1'b0}});
    nan_a   = is_nan(a_q);
    nan_b   = is_nan(b_q);
    inf_a   = is_inf(a_q);
    inf_b   = is_inf(b_q);
    sig_a   = zero_a ? {SW{1'b0}} : {1'b1, a_q[MAN_W-1:0], 3'b000};
    sig_b   = zero_b ? {SW{1'b0}} : {1'b1, b_q[MAN_W-1:0], 3'b000};

    a_big   = (a_q[W-2:0] >= b_q[W-2:0]);
    e_big   = a_big ? ea : eb;
    e_sml   = a_big ? eb : ea;
    s_big   = a_big ? sig_a : sig_b;
    s_sml   = a_big ? sig_b : sig_a;
    sml_al  = shr_sticky(s_sml, e_big - e_sml);
    sum     = eff_sub ? ({1'b0, s_big} - {1'b0, sml_al}) : ({1'b0, s_big} + {1'b0, sml_al});
    carry   = sum[SW];
    add_sig = carry ? (sum[SW:1] | {{(SW-1){1'b0}}, sum[0]}) : sum[SW-1:0];
    add_exp = EW'(e_big) + (carry ? EXP_INC : {EW{1'b0}});

    // Product sits in [1,4): its top bit lines up with the hidden bit, hence the +1.
    prod    = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});
    pext    = {prod, {SW{1'b0}}};
    mul_sig = pext[PW+SW-1:PW] | {{(SW-1){1'b0}}, |pext[PW-1:0]};
    mul_exp = EW'(ea) + EW'(eb) - EW'(BIAS) + EXP_INC;

    spec      = 1'b1;
    spec_inv  = 1'b0;
    spec_word = NAN_WORD;
    case (op_q)
      2'd0, 2'd1: begin
        if (nan_a || nan_b) begin
          spec_inv = 1'b1;
        end else if (inf_a && inf_b && eff_sub) begin
          spec_inv = 1'b1;
        end else if (inf_a) begin
          spec_word = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf_b) begin
          spec_word = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
          spec = 1'b0;
        end
      end
      2'd2: begin
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
          spec_inv = 1'b1;
        end else if (inf_a || inf_b) begin
          spec_word = {s_mul, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
          spec_word = {s_mul, {(W-1){1'b0}}};
        end else begin
          spec = 1'b0;
        end
      end
      default: spec_inv = 1'b1;
    endcase
  end

  // Round-to-nearest-even of the normalised significand plus range checks
  always_comb begin
    rnd_up   = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    rnd_lost = |sig_q[2:0];
    man_rnd  = {1'b0, sig_q[SW-1:3]} + (MAN_W+2)'(rnd_up);
    exp_rnd  = exp_q + (man_rnd[MAN_W+1] ? EXP_INC : {EW{1'b0}});
    if (!exp_rnd[EW-1] && (exp_rnd >= EXP_MAX)) begin
      rnd_word  = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (exp_rnd[EW-1] || (exp_rnd == {EW{1'b0}})) begin
      rnd_word  = {sign_q, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else begin
      rnd_word  = {sign_q, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
      rnd_flags = {3'b000, rnd_lost};
    end
  end

  // Control FSM next-state and register updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    spec_d      = spec_q;
    spec_inv_d  = spec_inv_q;
    spec_word_d = spec_word_q;
    result_d    = result_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        spec_d      = spec;
        spec_inv_d  = spec_inv;
        spec_word_d = spec_word;
        if (spec) begin
          state_d = ROUND;
        end else if (op_q == 2'd2) begin
          sign_d  = s_mul;
          exp_d   = mul_exp;
          sig_d   = mul_sig;
          state_d = NORM;
        end else begin
          sign_d  = a_big ? sa : sb_eff;
          exp_d   = add_exp;
          sig_d   = add_sig;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sig_q == {SW{1'b0}}) begin
          result_d = {W{1'b0}};
          flags_d  = 4'b0000;
          state_d  = DONE;
        end else if (sig_q[SW-1]) begin
          state_d = ROUND;
        end else begin
          sig_d = {sig_q[SW-2:0], 1'b0};
          exp_d = exp_q - EXP_INC;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (spec_q) begin
          result_d = spec_word_q;
          flags_d  = {spec_inv_q, 3'b000};
        end else begin
          result_d = rnd_word;
          flags_d  = rnd_flags;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sign_q      <= 1'b0;
      exp_q       <= {EW{1'b0}};
      sig_q       <= {SW{1'b0}};
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      spec_word_q <= {W{1'b0}};
      result_q    <= {W{1'b0}};
      flags_q     <= 4'b0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      spec_q      <= spec_d;
      spec_inv_q  <= spec_inv_d;
      spec_word_q <= spec_word_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq: default E4M3 instance plus an E5M2 instance.
module tb_fp_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op_i;
  logic [7:0] a_i, b_i;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0] result2;
  logic [3:0] flags2;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  fp_alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op_i),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_alu_seq #(.EXP_W(5), .MAN_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .op(op_i),
    .a(a_i), .b(b_i), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .flags(flags2)
  );

  // Issue one operation to the selected instance, return result, flags and latency.
  task automatic do_op(input bit sel, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    op_i = o; a_i = x; b_i = y;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
    lat = 0;
    while (((sel ? out_valid2 : out_valid) !== 1'b1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = (lat >= 40) ? 8'hxx : (sel ? result2 : result);
    f = (lat >= 40) ? 4'hx  : (sel ? flags2 : flags);
    if (sel) out_ready2 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, flags, result} !== {1'b1, 1'b0, 4'h0, 8'h00})
      $display("FAIL reset_e4m3: got %b want %b", {in_ready, out_valid, flags, result}, 14'b10_0000_00000000);
    else n_pass++;
    n_checks++;
    if ({in_ready2, out_valid2, flags2, result2} !== {1'b1, 1'b0, 4'h0, 8'h00})
      $display("FAIL reset_e5m2: got %b want %b", {in_ready2, out_valid2, flags2, result2}, 14'b10_0000_00000000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release: got %b want 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [7:0] r; logic [3:0] f; int lat;
    do_op(1'b0, 2'd2, 8'h3C, 8'h44, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h49, 4'h0}) $display("FAIL mul_1p5x3: got %h/%h want 49/0", r, f); else n_pass++;
    n_checks++;
    if (lat !== 3) $display("FAIL mul_latency: got %0d want 3", lat); else n_pass++;
    do_op(1'b0, 2'd2, 8'hBC, 8'h44, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'hC9, 4'h0}) $display("FAIL mul_neg: got %h/%h want c9/0", r, f); else n_pass++;
    do_op(1'b0, 2'd2, 8'h38, 8'h38, r, f, lat);
    n_checks++;
    if ({r, f, lat[3:0]} !== {8'h38, 4'h0, 4'd4}) $display("FAIL mul_1x1: got %h/%h lat %0d want 38/0 lat 4", r, f, lat);
    else n_pass++;
  endtask

  task automatic test_addsub();
    logic [7:0] r; logic [3:0] f; int lat;
    do_op(1'b0, 2'd1, 8'h44, 8'h3C, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h3C, 4'h0}) $display("FAIL sub_3m1p5: got %h/%h want 3c/0", r, f); else n_pass++;
    n_checks++;
    if (lat !== 4) $display("FAIL sub_latency: got %0d want 4", lat); else n_pass++;
    do_op(1'b0, 2'd1, 8'h44, 8'h44, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h00, 4'h0}) $display("FAIL sub_cancel: got %h/%h want 00/0", r, f); else n_pass++;
    do_op(1'b0, 2'd0, 8'h3C, 8'h3C, r, f, lat);
    n_checks++;
    if ({r, f, lat[3:0]} !== {8'h44, 4'h0, 4'd3}) $display("FAIL add_carry: got %h/%h lat %0d want 44/0 lat 3", r, f, lat);
    else n_pass++;
    do_op(1'b0, 2'd0, 8'h38, 8'hB8, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h00, 4'h0}) $display("FAIL add_opposite: got %h/%h want 00/0", r, f); else n_pass++;
  endtask

  task automatic test_rounding();
    logic [7:0] r; logic [3:0] f; int lat;
    do_op(1'b0, 2'd0, 8'h38, 8'h18, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h38, 4'h1}) $display("FAIL rne_tie_down: got %h/%h want 38/1", r, f); else n_pass++;
    do_op(1'b0, 2'd0, 8'h39, 8'h18, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h3A, 4'h1}) $display("FAIL rne_tie_up: got %h/%h want 3a/1", r, f); else n_pass++;
  endtask

  task automatic test_exceptions();
    logic [7:0] r; logic [3:0] f; int lat;
    do_op(1'b0, 2'd2, 8'h77, 8'h40, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h78, 4'h5}) $display("FAIL mul_overflow: got %h/%h want 78/5", r, f); else n_pass++;
    do_op(1'b0, 2'd2, 8'h78, 8'h00, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h7C, 4'h8}) $display("FAIL inf_x_zero: got %h/%h want 7c/8", r, f); else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL special_latency: got %0d want 2", lat); else n_pass++;
    do_op(1'b0, 2'd2, 8'h01, 8'h38, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h00, 4'h0}) $display("FAIL subnormal_flush: got %h/%h want 00/0", r, f); else n_pass++;
    do_op(1'b0, 2'd3, 8'h38, 8'h38, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h7C, 4'h8}) $display("FAIL op_reserved: got %h/%h want 7c/8", r, f); else n_pass++;
    do_op(1'b0, 2'd0, 8'h79, 8'h38, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h7C, 4'h8}) $display("FAIL nan_in: got %h/%h want 7c/8", r, f); else n_pass++;
    do_op(1'b0, 2'd1, 8'h78, 8'h78, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h7C, 4'h8}) $display("FAIL inf_minus_inf: got %h/%h want 7c/8", r, f); else n_pass++;
    do_op(1'b0, 2'd0, 8'hF8, 8'h38, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'hF8, 4'h0}) $display("FAIL neg_inf_plus: got %h/%h want f8/0", r, f); else n_pass++;
    do_op(1'b0, 2'd2, 8'h88, 8'h08, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h80, 4'h3}) $display("FAIL mul_underflow: got %h/%h want 80/3", r, f); else n_pass++;
  endtask

  task automatic test_handshake();
    int cyc;
    @(negedge clk);
    op_i = 2'd2; a_i = 8'h3C; b_i = 8'h44; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_i = 2'd0; a_i = 8'h38; b_i = 8'h38; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, flags, result} !== {1'b1, 1'b0, 4'h0, 8'h49})
        $display("FAIL hs_hold[%0d]: got %b want %b", i, {out_valid, in_ready, flags, result}, 14'b10_0000_01001001);
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL hs_release: got %b want 10", {in_ready, out_valid});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL hs_no_queue: got %b want 10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [7:0] r; logic [3:0] f; int lat;
    @(negedge clk);
    op_i = 2'd1; a_i = 8'h44; b_i = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL midop_busy: got in_ready %b want 0", in_ready); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, flags, result} !== {1'b1, 1'b0, 4'h0, 8'h00})
      $display("FAIL midop_async_reset: got %b want %b", {in_ready, out_valid, flags, result}, 14'b10_0000_00000000);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL midop_aborted: got %b want 10", {in_ready, out_valid});
    else n_pass++;
    do_op(1'b0, 2'd2, 8'h3C, 8'h44, r, f, lat);
    n_checks++;
    if ({r, f, lat[3:0]} !== {8'h49, 4'h0, 4'd3}) $display("FAIL midop_recover: got %h/%h lat %0d want 49/0 lat 3", r, f, lat);
    else n_pass++;
  endtask

  task automatic test_param();
    logic [7:0] r; logic [3:0] f; int lat;
    do_op(1'b1, 2'd2, 8'h3E, 8'h42, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h44, 4'h1}) $display("FAIL e5m2_mul: got %h/%h want 44/1", r, f); else n_pass++;
    n_checks++;
    if (lat !== 3) $display("FAIL e5m2_latency: got %0d want 3", lat); else n_pass++;
    do_op(1'b1, 2'd0, 8'h3C, 8'h3C, r, f, lat);
    n_checks++;
    if ({r, f} !== {8'h40, 4'h0}) $display("FAIL e5m2_add: got %h/%h want 40/0", r, f); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_i = 2'd0; a_i = 8'h00; b_i = 8'h00;
    in_valid = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    test_reset();
    test_mul();
    test_addsub();
    test_rounding();
    test_exceptions();
    test_handshake();
    test_reset_midop();
    test_param();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
